// File: rtl/mux_pkg.sv
// Shared definitions for the pipelined N-to-1 selector: state encoding and the
// state type used by the output-side skid-buffer FSM.
package mux_pkg;

    localparam logic [1:0] MUX_ST_EMPTY = 2'd0;
    localparam logic [1:0] MUX_ST_BUSY  = 2'd1;
    localparam logic [1:0] MUX_ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = MUX_ST_EMPTY,
        ST_BUSY  = MUX_ST_BUSY,
        ST_FULL  = MUX_ST_FULL
    } mux_state_e;

endpackage

// File: rtl/mux_nto1_comb.sv
// Purely combinational N-to-1 channel select; a select index with no matching
// channel (only reachable when N is not a power of two) yields an all-zero word.
module mux_nto1_comb #(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data
);

    always_comb begin
        out_data = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SEL_W'(k)) out_data = in_data[k*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/mux_nto1_pipe.sv
// N-to-1 selector feeding a two-entry skid buffer with valid/ready on both sides.
// Optional macro MUX_SEL_CHECK_EN builds the sticky out-of-range select flag.
//
//   state    | meaning
//   ST_EMPTY | nothing held, out_valid=0, in_ready=1
//   ST_BUSY  | output reg holds a word, in_ready=1
//   ST_FULL  | output and skid regs both hold words, in_ready=0
module mux_nto1_pipe
    import mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err
);

    mux_state_e       r_state;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_sel_word;
    logic             w_accept;
    logic             w_pop;

    mux_nto1_comb #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_sel (
        .in_data  (in_data),
        .sel      (sel),
        .out_data (w_sel_word)
    );

    // Ready is a function of registered state only, so no combinational path from out_ready.
    assign in_ready  = (r_state != ST_FULL) && !reset;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_out_data;
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_out_data <= '0;
            r_skid     <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state    <= ST_BUSY;
                        r_out_data <= w_sel_word;
                    end
                end
                ST_BUSY: begin
                    if (w_accept && w_pop) begin
                        r_out_data <= w_sel_word;
                    end else if (w_accept) begin
                        r_state <= ST_FULL;
                        r_skid  <= w_sel_word;
                    end else if (w_pop) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        r_state    <= ST_BUSY;
                        r_out_data <= r_skid;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

`ifdef MUX_SEL_CHECK_EN
    logic r_sel_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && (int'(sel) >= N)) begin
            r_sel_err <= 1'b1;
        end
    end

    assign sel_err = r_sel_err;
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed self-checking bench for mux_nto1_pipe: a default N=4/WIDTH=32 instance
// plus an N=3/WIDTH=8 instance for the out-of-range select behaviour.
module tb_mux_nto1_pipe;

    logic         clock = 1'b0;
    logic         reset = 1'b1;

    logic [127:0] in_data   = '0;
    logic [1:0]   sel       = '0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         sel_err;

    logic [23:0]  in_data3   = '0;
    logic [1:0]   sel3       = '0;
    logic         in_valid3  = 1'b0;
    logic         in_ready3;
    logic [7:0]   out_data3;
    logic         out_valid3;
    logic         out_ready3 = 1'b0;
    logic         sel_err3;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_stream [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    always #5 clock = ~clock;

    mux_nto1_pipe #(.WIDTH(32), .N(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    mux_nto1_pipe #(.WIDTH(8), .N(3)) dut3 (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data3),
        .sel       (sel3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .sel_err   (sel_err3)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // reset held
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_sel_err",   64'(sel_err),   64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // streaming, one word per cycle
        in_data   = {32'h44, 32'h33, 32'h22, 32'h11};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            tick();
            chk($sformatf("stream_valid%0d", i), 64'(out_valid), 64'd1);
            chk($sformatf("stream_data%0d", i),  64'(out_data),  64'(exp_stream[i]));
            chk($sformatf("stream_ready%0d", i), 64'(in_ready),  64'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain_valid", 64'(out_valid), 64'd0);

        // stall: fill both entries
        out_ready = 1'b0;
        sel       = 2'd0;
        in_data   = {32'h0, 32'h0, 32'h0, 32'hA};
        in_valid  = 1'b1;
        tick();
        chk("stall_a_data",  64'(out_data), 64'hA);
        chk("stall_a_ready", 64'(in_ready), 64'd1);
        in_data[31:0] = 32'hB;
        tick();
        chk("stall_full_ready", 64'(in_ready),  64'd0);
        chk("stall_full_valid", 64'(out_valid), 64'd1);

        // hold stability while upstream data wanders
        for (int i = 0; i < 5; i++) begin
            in_data = {32'h200 + 32'(i), 32'h300 + 32'(i), 32'h400 + 32'(i), 32'h100 + 32'(i)};
            tick();
            chk($sformatf("hold_data%0d", i), 64'(out_data), 64'hA);
        end

        in_data   = {32'h0, 32'h0, 32'h0, 32'hC};
        out_ready = 1'b1;
        #1;
        chk("full_ready_ignores_out_ready", 64'(in_ready), 64'd0);
        tick();
        chk("drain_b_data",  64'(out_data),  64'hB);
        chk("drain_b_valid", 64'(out_valid), 64'd1);
        tick();
        chk("drain_c_data",  64'(out_data),  64'hC);
        in_valid = 1'b0;
        tick();
        chk("drain_empty_valid", 64'(out_valid), 64'd0);

        // reset mid-stream with two words buffered
        out_ready = 1'b0;
        in_data   = {32'h0, 32'h0, 32'h0, 32'hD};
        in_valid  = 1'b1;
        tick();
        in_data[31:0] = 32'hE;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_full", 64'(in_ready), 64'd0);
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_data",  64'(out_data),  64'd0);
        chk("async_rst_ready", 64'(in_ready),  64'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rerst_in_ready", 64'(in_ready), 64'd1);
        chk("rerst_sel_err",  64'(sel_err),  64'd0);
        out_ready = 1'b1;
        tick();
        chk("rerst_no_ghost", 64'(out_valid), 64'd0);

        // N=3: out-of-range select passes as zero
        in_data3   = {8'h33, 8'h22, 8'h11};
        out_ready3 = 1'b1;
        in_valid3  = 1'b1;
        sel3       = 2'd3;
        tick();
        chk("n3_oor_valid", 64'(out_valid3), 64'd1);
        chk("n3_oor_data",  64'(out_data3),  64'd0);
`ifdef MUX_SEL_CHECK_EN
        chk("n3_sel_err_set", 64'(sel_err3), 64'd1);
`else
        chk("n3_sel_err_off", 64'(sel_err3), 64'd0);
`endif
        sel3 = 2'd1;
        tick();
        chk("n3_ch1_data", 64'(out_data3), 64'h22);
        sel3 = 2'd2;
        tick();
        chk("n3_ch2_data", 64'(out_data3), 64'h33);
`ifdef MUX_SEL_CHECK_EN
        chk("n3_sel_err_sticky", 64'(sel_err3), 64'd1);
`else
        chk("n3_sel_err_tied", 64'(sel_err3), 64'd0);
`endif
        chk("n4_sel_err_clear", 64'(sel_err), 64'd0);
        in_valid3 = 1'b0;
        tick();
        chk("n3_drain_valid", 64'(out_valid3), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_nto1_pipe.md
# mux_nto1_pipe

Parametrised N-to-1 selector with a registered, flow-controlled output: the next-generation replacement for the fixed 2:1 32-bit datapath mux. Captures the word chosen by `sel` from N input channels and presents it through a two-entry skid buffer with valid/ready handshaking on both sides. Sits between MIPS pipeline stages where operand or forwarding selection must absorb downstream stalls without dropping data.

## Interface
- `WIDTH`, 32, data word width in bits (≥1)
- `N`, 4, number of input channels (≥2)
- `SEL_W`, `$clog2(N)`, select width; derived, never overridden
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `in_data`  in  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- `sel`  in  SEL_W  channel index, sampled with `in_data`
- `in_valid`  in  1  upstream word and `sel` are valid
- `in_ready`  out  1  block can accept this cycle
- `out_data`  out  WIDTH  selected word
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  downstream accepts this cycle
- `sel_err`  out  1  sticky out-of-range select flag (see Configuration)

## Operation
- Accept = `in_valid && in_ready`; pop = `out_valid && out_ready`.
- Selected word = channel `sel`; if `sel >= N` (only possible when N is not a power of two), selected word = 0.
- Three states, held in a 2-bit state register:
  - EMPTY: `out_valid`=0, `in_ready`=1. Accept → BUSY, output reg ← selected word.
  - BUSY: `out_valid`=1, `in_ready`=1. Accept & pop → BUSY, output reg ← new word. Accept & !pop → FULL, skid reg ← new word. Pop & !accept → EMPTY. Neither → hold.
  - FULL: `out_valid`=1, `in_ready`=0. Pop → BUSY, output reg ← skid reg. No pop → hold.
- `in_ready` = (state != FULL) && !`reset`; depends on registered state only, never on `out_ready`.
- `out_data` must be stable while `out_valid && !out_ready`.
- Ordering is strict FIFO; no word is dropped or duplicated.

## Timing
- Reset (asynchronous): state EMPTY, `out_valid`=0, `out_data`=0, skid reg=0, `sel_err`=0, `in_ready`=0 while `reset` is high.
- Latency: accept at edge t → `out_valid`=1 with that word after edge t.
- Throughput: one word per cycle while `out_ready` is held high.
- Simultaneous accept and pop in BUSY: the pop retires the old word and the new word replaces it at the same edge.
- Reset mid-operation: both stored words are discarded and `out_valid` drops without waiting for a clock edge.
- `out_ready` without `out_valid`: ignored.

## Configuration
- `MUX_SEL_CHECK_EN` defined: `sel_err` is set on any accept with `sel >= N` and stays set until reset. The offending word still passes as 0.
- Not defined: `sel_err` is tied to 0 and no check logic is built. The port is always present.

## Structure
- Shared package `mux_pkg`: state encoding constants `MUX_ST_EMPTY`=2'd0, `MUX_ST_BUSY`=2'd1, `MUX_ST_FULL`=2'd2.
- Sub-module `mux_nto1_comb` (WIDTH, N): purely combinational channel select with the zero-on-out-of-range rule. Reused elsewhere in the datapath.
- The top level holds the state register, the output and skid registers, and the `sel_err` logic.

## Test plan
- Reset, N=4/WIDTH=32: assert `reset` mid-stream with two words buffered → `out_valid`=0 and `out_data`=0 immediately. After release, `in_ready`=1 and `sel_err`=0.
- Streaming: channels = {0x44,0x33,0x22,0x11} (ch3..ch0), `out_ready`=1, sel = 0,1,2,3 on consecutive cycles → outputs 0x11, 0x22, 0x33, 0x44 on consecutive cycles, one cycle after each accept.
- Stall: `out_ready`=0, send 0xA then 0xB → FULL and `in_ready`=0. Third word 0xC held upstream. Raise `out_ready` → 0xA, 0xB, 0xC in order, with no loss.
- Hold stability: `out_valid`=1, `out_ready`=0 for 5 cycles while `in_data` changes → `out_data` unchanged.
- Simultaneous accept and pop in BUSY → state remains BUSY and `out_data` updates to the new word the next cycle.
- N=3 with `MUX_SEL_CHECK_EN`: `sel`=3 → `out_data`=0 and `sel_err`=1, and `sel_err` stays 1 after later valid selects. Without the macro → `sel_err`=0.
